apb4_regfile_slave: RTL and testbench

- Parametrised APB4 register-file slave; the next generation of our fixed four-register APB example slave.
- Provides NUM_REGS byte-strobed read/write registers and a CoreSight-style PID/CID block at 0xFD0-0xFFC.
- Adds programmable wait states, a proper SETUP/ACCESS state machine, and full PSLVERR decode.
- Register contents and per-register write pulses go out to core logic.

---
 rtl/apb4_regfile_slave_if.sv | 39 +++
 rtl/apb4_regfile_slave.sv | 210 +++++++++++++++++++++
 tb/tb_apb4_regfile_slave.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb4_regfile_slave_if.sv
// ---------------------------------------------------------------------------
// apb4_regfile_slave_if
//   APB4 bus bundle used between a requester and apb4_regfile_slave.
//
//   Signals
//     psel     requester -> completer  slave select
//     penable  requester -> completer  access phase marker
//     pwrite   requester -> completer  1 = write, 0 = read
//     paddr    requester -> completer  byte address, [1:0] not decoded
//     pwdata   requester -> completer  write data
//     pstrb    requester -> completer  byte write strobes
//     prdata   completer -> requester  read data
//     pready   completer -> requester  transfer complete
//     pslverr  completer -> requester  error response, qualified by pready
// ---------------------------------------------------------------------------
interface apb4_regfile_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [3:0]            pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb4_regfile_slave
//   APB4 completer with NUM_REGS byte-strobed read/write registers at 0x000
//   upward, a read-only CoreSight-style PID/CID block at 0xFD0-0xFFC, a
//   reserved read-as-zero window at 0xFC0-0xFCC, programmable wait states
//   and full PSLVERR decode.
//
//   Ports
//     pclk       APB clock
//     rstn       asynchronous active-low reset
//     apb        APB4 bus (slave modport): psel/penable/pwrite/paddr/pwdata/
//                pstrb in, prdata/pready/pslverr out
//     ecorevnum  ECO revision, returned in PID3[7:4]
//     reg_out    flattened register contents, reg k at [32k +: 32]
//     wr_pulse   one-cycle pulse for reg k on the cycle after a write to it
//
//   prdata/pready/pslverr are combinational from the FSM state, the wait
//   counter and the decode latched when SETUP moves to ACCESS. Everything
//   else is registered.
// ---------------------------------------------------------------------------
module apb4_regfile_slave #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                           pclk,
  input  logic                           rstn,
  apb4_regfile_slave_if.slave            apb,
  input  logic [3:0]                     ecorevnum,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  typedef enum logic [1:0] {
    DEC_RW,
    DEC_ID,
    DEC_RSV,
    DEC_UNMAP
  } dec_e;

  // Mask selecting the low 12 address bits; anything above must be zero for
  // the register, ID and reserved windows to match.
  localparam logic [ADDR_WIDTH-1:0] LOW12 = ADDR_WIDTH'(12'hFFF);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  wr_q;
  logic [3:0]            strb_q;
  dec_e                  dec_q;
  logic [5:0]            widx_q;
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic                  done;
  logic [DATA_WIDTH-1:0] rd_reg;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  pslverr_d;

  // Address classification. Register indices never exceed 63, so the RW
  // window always sits below the reserved/ID block at 0xFC0.
  function automatic dec_e decode(input logic [ADDR_WIDTH-1:0] a);
    logic upper_zero;
    dec_e d;
    upper_zero = ((a & ~LOW12) == '0);
    d = DEC_UNMAP;
    if (upper_zero) begin
      if (a[11:2] < 10'(NUM_REGS))
        d = DEC_RW;
      else if (a[11:4] >= 8'hFD)
        d = DEC_ID;
      else if (a[11:4] == 8'hFC)
        d = DEC_RSV;
    end
    return d;
  endfunction

  // PID/CID contents indexed by word offset inside the 0xFC0 block
  // (4 = 0xFD0 ... 15 = 0xFFC).
  function automatic logic [31:0] id_word(input logic [3:0] idx,
                                          input logic [3:0] eco);
    logic [31:0] v;
    case (idx)
      4'd4:    v = 32'h0000_0004;           // PID4
      4'd8:    v = 32'h0000_0019;           // PID0
      4'd9:    v = 32'h0000_00B8;           // PID1
      4'd10:   v = 32'h0000_001B;           // PID2
      4'd11:   v = {24'h0, eco, 4'h0};      // PID3
      4'd12:   v = 32'h0000_000D;           // CID0
      4'd13:   v = 32'h0000_00F0;           // CID1
      4'd14:   v = 32'h0000_0005;           // CID2
      4'd15:   v = 32'h0000_00B1;           // CID3
      default: v = 32'h0;                   // PID5-7
    endcase
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [3:0]            strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // The last ACCESS cycle: counter has run out.
  assign done = (state_q == S_ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    rd_reg = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (widx_q == 6'(k)) rd_reg = regs_q[k];
  end

  always_comb begin
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (done) begin
      case (dec_q)
        DEC_RW: begin
          if (!wr_q) prdata_d = rd_reg;
        end
        DEC_ID: begin
          if (wr_q) pslverr_d = 1'b1;
          else      prdata_d  = id_word(widx_q[3:0], ecorevnum);
        end
        DEC_RSV: begin
          pslverr_d = wr_q;
        end
        default: begin
          pslverr_d = 1'b1;
        end
      endcase
    end
  end

  assign apb.pready  = done;
  assign apb.pslverr = pslverr_d;
  assign apb.prdata  = prdata_d;

  always_ff @(posedge pclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      strb_q     <= 4'h0;
      dec_q      <= DEC_UNMAP;
      widx_q     <= 6'd0;
      wr_pulse_q <= '0;
      for (int k = 0; k < NUM_REGS; k++)
        regs_q[k] <= RESET_VAL;
    end else begin
      wr_pulse_q <= '0;
      case (state_q)
        S_IDLE: begin
          // psel & penable here is a protocol violation and is ignored.
          if (apb.psel && !apb.penable)
            state_q <= S_SETUP;
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
          wr_q    <= apb.pwrite;
          strb_q  <= apb.pstrb;
          dec_q   <= decode(apb.paddr);
          widx_q  <= apb.paddr[7:2];
          cnt_q   <= 4'(WAIT_STATES);
        end
        S_ACCESS: begin
          if (!apb.psel) begin
            // Requester abandoned the transfer: no update, no pulse.
            state_q <= S_IDLE;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (wr_q && (dec_q == DEC_RW)) begin
              for (int k = 0; k < NUM_REGS; k++) begin
                if (widx_q == 6'(k)) begin
                  regs_q[k]     <= merge_bytes(regs_q[k], apb.pwdata, strb_q);
                  wr_pulse_q[k] <= 1'b1;
                end
              end
            end
            // A new setup phase presented in the completion cycle chains
            // straight into the next transfer.
            state_q <= (apb.psel && !apb.penable) ? S_SETUP : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_pulse = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_apb4_regfile_slave.sv
`timescale 1ns/1ps
module tb_apb4_regfile_slave;
  localparam int AW = 12;
  localparam int NR = 8;

  logic clk = 1'b0;
  logic rstn;
  logic psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [31:0] pwdata;
  logic [3:0] pstrb, ecorevnum;
  int cur = 0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb4_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus0 ();
  apb4_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus1 ();
  apb4_regfile_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus2 ();

  assign bus0.psel = psel && (cur == 0);
  assign bus1.psel = psel && (cur == 1);
  assign bus2.psel = psel && (cur == 2);
  assign bus0.penable = penable; assign bus1.penable = penable; assign bus2.penable = penable;
  assign bus0.pwrite  = pwrite;  assign bus1.pwrite  = pwrite;  assign bus2.pwrite  = pwrite;
  assign bus0.paddr   = paddr;   assign bus1.paddr   = paddr;   assign bus2.paddr   = paddr;
  assign bus0.pwdata  = pwdata;  assign bus1.pwdata  = pwdata;  assign bus2.pwdata  = pwdata;
  assign bus0.pstrb   = pstrb;   assign bus1.pstrb   = pstrb;   assign bus2.pstrb   = pstrb;

  logic [NR*32-1:0] ro0, ro1, ro2;
  logic [NR-1:0] wp0, wp1, wp2;

  apb4_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(0),
                       .RESET_VAL(32'h0)) dut0 (
    .pclk(clk), .rstn(rstn), .apb(bus0), .ecorevnum(ecorevnum), .reg_out(ro0), .wr_pulse(wp0));
  apb4_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(3),
                       .RESET_VAL(32'h0)) dut1 (
    .pclk(clk), .rstn(rstn), .apb(bus1), .ecorevnum(ecorevnum), .reg_out(ro1), .wr_pulse(wp1));
  apb4_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(2),
                       .RESET_VAL(32'h5A5A0F0F)) dut2 (
    .pclk(clk), .rstn(rstn), .apb(bus2), .ecorevnum(ecorevnum), .reg_out(ro2), .wr_pulse(wp2));

  logic [31:0] prdata_m;
  logic pready_m, pslverr_m;
  logic [NR*32-1:0] reg_out_m;
  logic [NR-1:0] wr_pulse_m;

  always_comb begin
    case (cur)
      1: begin prdata_m = bus1.prdata; pready_m = bus1.pready; pslverr_m = bus1.pslverr;
               reg_out_m = ro1; wr_pulse_m = wp1; end
      2: begin prdata_m = bus2.prdata; pready_m = bus2.pready; pslverr_m = bus2.pslverr;
               reg_out_m = ro2; wr_pulse_m = wp2; end
      default: begin prdata_m = bus0.prdata; pready_m = bus0.pready; pslverr_m = bus0.pslverr;
               reg_out_m = ro0; wr_pulse_m = wp0; end
    endcase
  end

  // ---------------- reference model ----------------
  logic [31:0] mdl [3][NR];
  int ws_of [3] = '{0, 3, 2};
  logic [31:0] rv_of [3] = '{32'h0, 32'h0, 32'h5A5A0F0F};

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < NR; k++) mdl[d][k] = rv_of[d];
  endtask

  // off = word offset from 0xFD0 (0..11)
  function automatic logic [31:0] id_expect(input int off);
    logic [7:0] tab [12];
    tab = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h19, 8'hB8, 8'h1B, 8'h00, 8'h0D, 8'hF0, 8'h05, 8'hB1};
    if (off == 7) return {24'h0, ecorevnum, 4'h0};
    return {24'h0, tab[off]};
  endfunction

  task automatic model_xfer(input int d, input bit wr, input logic [AW-1:0] a,
                            input logic [31:0] wd, input logic [3:0] s,
                            output logic [31:0] erd, output bit eerr, output logic [NR-1:0] ewp);
    int ai, w;
    ai = int'(a);
    w = ai / 4;
    erd = 32'h0; eerr = 1'b0; ewp = '0;
    if (w < NR) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) mdl[d][w][8*b +: 8] = wd[8*b +: 8];
        ewp[w] = 1'b1;
      end else begin
        erd = mdl[d][w];
      end
    end else if (ai >= 'hFD0) begin
      if (wr) eerr = 1'b1;
      else erd = id_expect(w - 'h3F4);
    end else if (ai >= 'hFC0) begin
      eerr = wr;
    end else begin
      eerr = 1'b1;
    end
  endtask

  // ---------------- bus driver ----------------
  // lat: number of penable cycles up to and including the pready cycle (0 = timeout)
  // bad: wait cycles in which prdata or pslverr was not zero
  task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input bit chained, input bit chain_next,
                      input bit nwr, input logic [AW-1:0] na, input logic [3:0] ns,
                      output logic [31:0] rd, output logic err, output int lat,
                      output int bad, output logic [NR-1:0] wp);
    bit got;
    if (!chained) begin
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pstrb = s;
      if (wr) pwdata = wd;
    end
    @(posedge clk); #1;
    penable = 1'b1;
    if (chained && wr) pwdata = wd;
    got = 1'b0; lat = 0; bad = 0; rd = 32'h0; err = 1'b0; wp = '0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (pready_m === 1'b1) begin
        got = 1'b1; lat = k; rd = prdata_m; err = pslverr_m;
      end else if (prdata_m !== 32'h0 || pslverr_m !== 1'b0) begin
        bad++;
      end
    end
    if (got && chain_next) begin
      penable = 1'b0; pwrite = nwr; paddr = na; pstrb = ns;
    end else begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      wp = wr_pulse_m;
    end
  endtask

  task automatic simple(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output logic err,
                        output int lat, output int bad, output logic [NR-1:0] wp);
    xfer(wr, a, wd, s, 1'b0, 1'b0, 1'b0, '0, 4'h0, rd, err, lat, bad, wp);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pstrb = '0;
    ecorevnum = 4'hA;
    model_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cur = d; #1;
      checks++; if (pready_m !== 1'b0) begin failures++;
        $display("FAIL reset_pready dut%0d got=%b exp=0", d, pready_m); end
      checks++; if (pslverr_m !== 1'b0 || prdata_m !== 32'h0) begin failures++;
        $display("FAIL reset_resp dut%0d pslverr=%b prdata=%h exp 0/0", d, pslverr_m, prdata_m); end
      checks++; if (wr_pulse_m !== '0) begin failures++;
        $display("FAIL reset_wr_pulse dut%0d got=%h exp=0", d, wr_pulse_m); end
      checks++; if (reg_out_m !== {NR{rv_of[d]}}) begin failures++;
        $display("FAIL reset_reg_out dut%0d got=%h exp=%h", d, reg_out_m, {NR{rv_of[d]}}); end
    end
    @(negedge clk); rstn = 1'b1;
    cur = 0;
  endtask

  task automatic test_basic_rw();
    logic [31:0] rd, erd; logic err; bit eerr; int lat, bad; logic [NR-1:0] wp, ewp;
    cur = 0;
    model_xfer(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF, erd, eerr, ewp);
    simple(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, rd, err, lat, bad, wp);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_wr_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0 || bad != 0) begin failures++;
      $display("FAIL basic_wr_resp pslverr=%b bad=%0d exp 0/0", err, bad); end
    checks++; if (wp !== 8'b0000_0010) begin failures++; $display("FAIL basic_wr_pulse got=%b exp=00000010", wp); end
    @(negedge clk);
    checks++; if (wr_pulse_m !== '0) begin failures++; $display("FAIL basic_pulse_single got=%b exp=0", wr_pulse_m); end
    checks++; if (reg_out_m[63:32] !== 32'hDEADBEEF) begin failures++;
      $display("FAIL basic_reg_out got=%h exp=deadbeef", reg_out_m[63:32]); end
    simple(1'b0, 12'h004, 32'h0, 4'h0, rd, err, lat, bad, wp);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
    checks++; if (lat != 2 || err !== 1'b0) begin failures++;
      $display("FAIL basic_rd_resp lat=%0d pslverr=%b exp 2/0", lat, err); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd, erd; logic err; bit eerr; int lat, bad; logic [NR-1:0] wp, ewp;
    cur = 0;
    model_xfer(0, 1'b1, 12'h000, 32'hAAAAAAAA, 4'hF, erd, eerr, ewp);
    simple(1'b1, 12'h000, 32'hAAAAAAAA, 4'hF, rd, err, lat, bad, wp);
    model_xfer(0, 1'b1, 12'h000, 32'h11223344, 4'h5, erd, eerr, ewp);
    simple(1'b1, 12'h000, 32'h11223344, 4'h5, rd, err, lat, bad, wp);
    checks++; if (reg_out_m[31:0] !== 32'hAA22AA44) begin failures++;
      $display("FAIL strb_merge got=%h exp=aa22aa44", reg_out_m[31:0]); end
    model_xfer(0, 1'b1, 12'h000, 32'h55667788, 4'h0, erd, eerr, ewp);
    simple(1'b1, 12'h000, 32'h55667788, 4'h0, rd, err, lat, bad, wp);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL strb_zero_err got=%b exp=0", err); end
    checks++; if (wp !== ewp) begin failures++; $display("FAIL strb_zero_pulse got=%b exp=%b", wp, ewp); end
    model_xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, erd, eerr, ewp);
    simple(1'b0, 12'h000, 32'h0, 4'h0, rd, err, lat, bad, wp);
    checks++; if (rd !== 32'hAA22AA44 || rd !== erd) begin failures++;
      $display("FAIL strb_zero_data got=%h exp=%h", rd, erd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, rd2, erd; logic err, err2; bit eerr; int lat, lat2, bad, bad2;
    logic [NR-1:0] wp, ewp;
    cur = 1;
    model_xfer(1, 1'b0, 12'h000, 32'h0, 4'h0, erd, eerr, ewp);
    simple(1'b0, 12'h000, 32'h0, 4'h0, rd, err, lat, bad, wp);
    checks++; if (lat != 5) begin failures++; $display("FAIL ws3_latency got=%0d exp=5", lat); end
    checks++; if (bad != 0) begin failures++; $display("FAIL ws3_wait_resp nonzero_cycles=%0d exp=0", bad); end
    checks++; if (rd !== erd || err !== 1'b0) begin failures++;
      $display("FAIL ws3_read got=%h/%b exp=%h/0", rd, err, erd); end
    // write chained directly into a read of the same register
    model_xfer(1, 1'b1, 12'h008, 32'hC0FFEE11, 4'hF, erd, eerr, ewp);
    xfer(1'b1, 12'h008, 32'hC0FFEE11, 4'hF, 1'b0, 1'b1, 1'b0, 12'h008, 4'h0, rd, err, lat, bad, wp);
    model_xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, erd, eerr, ewp);
    xfer(1'b0, 12'h008, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, '0, 4'h0, rd2, err2, lat2, bad2, wp);
    checks++; if (lat != 5 || lat2 != 5) begin failures++;
      $display("FAIL b2b_latency got=%0d,%0d exp=5,5", lat, lat2); end
    checks++; if (rd2 !== erd || rd2 !== 32'hC0FFEE11) begin failures++;
      $display("FAIL b2b_read got=%h exp=%h", rd2, erd); end
    checks++; if (err !== 1'b0 || err2 !== 1'b0 || bad + bad2 != 0) begin failures++;
      $display("FAIL b2b_resp pslverr=%b,%b bad=%0d exp 0,0,0", err, err2, bad + bad2); end
  endtask

  task automatic test_id_space();
    logic [31:0] rd, erd; logic err; bit eerr; int lat, bad; logic [NR-1:0] wp, ewp;
    logic [31:0] exp_fixed [3];
    logic [AW-1:0] fixed_addr [3];
    cur = 0; ecorevnum = 4'hA;
    fixed_addr = '{12'hFEC, 12'hFE4, 12'hFFC};
    exp_fixed  = '{32'h000000A0, 32'h000000B8, 32'h000000B1};
    for (int i = 0; i < 3; i++) begin
      simple(1'b0, fixed_addr[i], 32'h0, 4'h0, rd, err, lat, bad, wp);
      checks++; if (rd !== exp_fixed[i] || err !== 1'b0) begin failures++;
        $display("FAIL id_fixed addr=%h got=%h/%b exp=%h/0", fixed_addr[i], rd, err, exp_fixed[i]); end
    end
    model_xfer(0, 1'b1, 12'hFE0, 32'hFFFFFFFF, 4'hF, erd, eerr, ewp);
    simple(1'b1, 12'hFE0, 32'hFFFFFFFF, 4'hF, rd, err, lat, bad, wp);
    checks++; if (err !== 1'b1 || wp !== '0) begin failures++;
      $display("FAIL id_write pslverr=%b wr_pulse=%b exp 1/0", err, wp); end
    simple(1'b0, 12'hFE0, 32'h0, 4'h0, rd, err, lat, bad, wp);
    checks++; if (rd !== 32'h19) begin failures++; $display("FAIL id_after_write got=%h exp=19", rd); end
    for (int i = 0; i < 12; i++) begin
      logic [AW-1:0] a;
      a = AW'('hFD0 + 4 * i);
      model_xfer(0, 1'b0, a, 32'h0, 4'h0, erd, eerr, ewp);
      simple(1'b0, a, 32'h0, 4'h0, rd, err, lat, bad, wp);
      checks++; if (rd !== erd || err !== eerr) begin failures++;
        $display("FAIL id_table addr=%h got=%h/%b exp=%h/%b", a, rd, err, erd, eerr); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic err; bit eerr; int lat, bad; logic [NR-1:0] wp, ewp;
    cur = 0;
    simple(1'b0, 12'h020, 32'h0, 4'h0, rd, err, lat, bad, wp);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++;
      $display("FAIL unmapped_read got=%h/%b exp=0/1", rd, err); end
    model_xfer(0, 1'b1, 12'h7F0, 32'h12345678, 4'hF, erd, eerr, ewp);
    simple(1'b1, 12'h7F0, 32'h12345678, 4'hF, rd, err, lat, bad, wp);
    checks++; if (err !== 1'b1 || wp !== '0) begin failures++;
      $display("FAIL unmapped_write pslverr=%b wr_pulse=%b exp 1/0", err, wp); end
    simple(1'b0, 12'hFC4, 32'h0, 4'h0, rd, err, lat, bad, wp);
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin failures++;
      $display("FAIL reserved_read got=%h/%b exp=0/0", rd, err); end
    simple(1'b1, 12'hFC8, 32'hFFFFFFFF, 4'hF, rd, err, lat, bad, wp);
    checks++; if (err !== 1'b1 || wp !== '0) begin failures++;
      $display("FAIL reserved_write pslverr=%b wr_pulse=%b exp 1/0", err, wp); end
    checks++; if (reg_out_m !== {mdl[0][7], mdl[0][6], mdl[0][5], mdl[0][4],
                                 mdl[0][3], mdl[0][2], mdl[0][1], mdl[0][0]}) begin failures++;
      $display("FAIL error_no_update got=%h", reg_out_m); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic err; bit eerr; int lat, bad; logic [NR-1:0] wp, ewp;
    cur = 2;
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h00C; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1; penable = 1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (pready_m !== 1'b0) begin failures++; $display("FAIL midrst_pre_pready got=%b exp=0", pready_m); end
    rstn = 1'b0; #1;
    checks++; if (pready_m !== 1'b0 || pslverr_m !== 1'b0) begin failures++;
      $display("FAIL midrst_resp pready=%b pslverr=%b exp 0/0", pready_m, pslverr_m); end
    @(posedge clk); #1; psel = 0; penable = 0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    checks++; if (reg_out_m[127:96] !== rv_of[2] || wr_pulse_m !== '0) begin failures++;
      $display("FAIL midrst_reg got=%h pulse=%b exp=%h/0", reg_out_m[127:96], wr_pulse_m, rv_of[2]); end
    simple(1'b0, 12'h00C, 32'h0, 4'h0, rd, err, lat, bad, wp);
    checks++; if (rd !== 32'h5A5A0F0F || lat != 4 || err !== 1'b0) begin failures++;
      $display("FAIL midrst_next_read got=%h lat=%0d pslverr=%b exp=5a5a0f0f/4/0", rd, lat, err); end
    model_xfer(2, 1'b1, 12'h00C, 32'hCAFEF00D, 4'hF, erd, eerr, ewp);
    simple(1'b1, 12'h00C, 32'hCAFEF00D, 4'hF, rd, err, lat, bad, wp);
    checks++; if (wp !== ewp || lat != 4) begin failures++;
      $display("FAIL midrst_next_write pulse=%b lat=%0d exp=%b/4", wp, lat, ewp); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, wd; logic err; bit eerr; int lat, bad; logic [NR-1:0] wp, ewp;
    logic [AW-1:0] a; logic [3:0] s; bit wr; int cat;
    for (int it = 0; it < 90; it++) begin
      cur = int'($urandom_range(0, 2));
      ecorevnum = 4'($urandom);
      wr = 1'($urandom);
      wd = $urandom;
      s = 4'($urandom);
      cat = int'($urandom_range(0, 9));
      if (cat <= 5)      a = AW'(4 * $urandom_range(0, NR - 1));
      else if (cat == 6) a = AW'('hFD0 + 4 * $urandom_range(0, 11));
      else if (cat == 7) a = AW'('hFC0 + 4 * $urandom_range(0, 3));
      else               a = AW'('h020 + 4 * $urandom_range(0, ('hFC0 - 'h020) / 4 - 1));
      a[1:0] = 2'($urandom);
      model_xfer(cur, wr, a, wd, s, erd, eerr, ewp);
      simple(wr, a, wd, s, rd, err, lat, bad, wp);
      checks++; if (rd !== erd || err !== eerr) begin failures++;
        $display("FAIL rand_resp it=%0d dut%0d wr=%b addr=%h got=%h/%b exp=%h/%b",
                 it, cur, wr, a, rd, err, erd, eerr); end
      checks++; if (lat != ws_of[cur] + 2 || bad != 0) begin failures++;
        $display("FAIL rand_timing it=%0d dut%0d lat=%0d bad=%0d exp=%0d/0", it, cur, lat, bad, ws_of[cur] + 2); end
      checks++; if (wp !== ewp) begin failures++;
        $display("FAIL rand_pulse it=%0d dut%0d got=%b exp=%b", it, cur, wp, ewp); end
    end
    for (int d = 0; d < 3; d++) begin
      cur = d; #1;
      for (int k = 0; k < NR; k++) begin
        checks++; if (reg_out_m[32*k +: 32] !== mdl[d][k]) begin failures++;
          $display("FAIL rand_final dut%0d reg%0d got=%h exp=%h", d, k, reg_out_m[32*k +: 32], mdl[d][k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_strobes();
    test_wait_states();
    test_id_space();
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
